// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the VGA timing generator to the pattern stage.
interface vga_timing_gen_if;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        pix_valid;
  logic        line_start;
  logic        frame_start;
  logic [31:0] frame_count;
  logic        hsync_d;
  logic        vsync_d;
  logic        de_d;

  modport master (
    output x, y, pix_valid, line_start, frame_start, frame_count,
    output hsync_d, vsync_d, de_d
  );

  modport slave (
    input x, y, pix_valid, line_start, frame_start, frame_count,
    input hsync_d, vsync_d, de_d
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: active-relative pixel coordinates, pixel-valid,
// line/frame pulses, a frame counter, and sync/DE delayed to match the
// downstream pattern pipeline.
module vga_timing_gen #(
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 29,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 4
) (
  input  logic          clk,
  input  logic          reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_BEG  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] V_ACT_BEG  = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_SYNC + V_BP + V_ACTIVE);

  logic [CW-1:0] hc, vc;
  logic          started;

  logic          h_act_c, v_act_c, pv_c, hs_raw_c, vs_raw_c;

  logic [CW-1:0] x_q, y_q;
  logic          pv_q, ls_q, fs_q, hs_q, vs_q;
  logic [31:0]   fc_q;

  // Decode the current counter position into regions.
  always_comb begin
    h_act_c  = (hc >= H_ACT_BEG) && (hc < H_ACT_END);
    v_act_c  = (vc >= V_ACT_BEG) && (vc < V_ACT_END);
    pv_c     = h_act_c && v_act_c;
    hs_raw_c = (hc < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vs_raw_c = (vc < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
  end

  // Horizontal/vertical position counters, free-running with no stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + CW'(1);
    end else begin
      hc <= hc + CW'(1);
    end
  end

  // Aligned outputs: one register stage reflecting the previous position.
  // The frame counter steps together with frame_start, except for the very
  // first frame after reset, so it reads N throughout frame N.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      pv_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
      started <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
    end else begin
      x_q     <= pv_c ? hc - H_ACT_BEG : '0;
      y_q     <= pv_c ? vc - V_ACT_BEG : '0;
      pv_q    <= pv_c;
      ls_q    <= (hc == '0);
      fs_q    <= (hc == '0) && (vc == '0);
      if ((hc == '0) && (vc == '0) && started) begin
        fc_q <= fc_q + 32'd1;
      end
      started <= 1'b1;
      hs_q    <= hs_raw_c;
      vs_q    <= vs_raw_c;
    end
  end

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.pix_valid   = pv_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_count = fc_q;

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign vga.hsync_d = hs_q;
      assign vga.vsync_d = vs_q;
      assign vga.de_d    = pv_q;
    end else begin : g_delay
      // Delay line of {hsync, vsync, de}; reset flushes every stage to idle.
      logic [2:0] dly_q [PIPE_DELAY];

      // Shift the aligned sync/DE through PIPE_DELAY stages.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < int'(PIPE_DELAY); i++) begin
            dly_q[i] <= {~SYNC_POL, ~SYNC_POL, 1'b0};
          end
        end else begin
          dly_q[0] <= {hs_q, vs_q, pv_q};
          for (int i = 1; i < int'(PIPE_DELAY); i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end

      assign {vga.hsync_d, vga.vsync_d, vga.de_d} = dly_q[PIPE_DELAY-1];
    end
  endgenerate

endmodule
